// File: rtl/ram_link_master_if.sv
// Bus bundle between the on-chip controller, the UART TX/RX cores and
// ram_link_master.
//   req_*  : request handshake from the controller (valid/ready, write, addr, data)
//   tx_*   : byte stream to the UART transmitter (data, strobe, busy back-pressure)
//   rx_*   : byte stream from the UART receiver (data, strobe)
//   rsp_*  : completion pulse with data and status qualifiers
// modport master: the link master's view; modport slave: the surrounding system.
interface ram_link_master_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 16;

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_data_i;
    logic [BYTE_W-1:0] tx_data_o;
    logic              new_tx_data_o;
    logic              tx_busy_i;
    logic [BYTE_W-1:0] rx_data_i;
    logic              new_rx_data_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_timeout_o;
    logic              rsp_mismatch_o;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_data_i,
        input  tx_busy_i, rx_data_i, new_rx_data_i,
        output req_ready_o, tx_data_o, new_tx_data_o,
        output rsp_valid_o, rsp_data_o, rsp_timeout_o, rsp_mismatch_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_data_i,
        output tx_busy_i, rx_data_i, new_rx_data_i,
        input  req_ready_o, tx_data_o, new_tx_data_o,
        input  rsp_valid_o, rsp_data_o, rsp_timeout_o, rsp_mismatch_o
    );
endinterface

// File: rtl/ram_link_master.sv
// Host-side initiator for the byte-serial block RAM link. Serialises one
// read/write request into HEADER, addr, r/w, [data lo, data hi] on the UART
// transmitter and collects the HEADER, data lo, data hi read response.
// Ports:
//   clk_i    : clock
//   rst_n_i  : asynchronous active-low reset
//   bus      : ram_link_master_if.master (request, tx, rx and response signals)
// Optional feature macro: RAM_LINK_MASTER_WRITE_VERIFY_EN -- every write is
// followed by a read-back of the same address and completion reports a
// data mismatch. Without it writes complete on the last transmitted byte.
module ram_link_master #(
    parameter logic [7:0]  HEADER_BYTE    = 8'h55,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_WIDTH  = 20
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    ram_link_master_if.master bus
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TX_HEADER,
        ST_TX_ADDR,
        ST_TX_RW,
        ST_TX_LOW,
        ST_TX_HIGH,
        ST_RX_HEADER,
        ST_RX_LOW,
        ST_RX_HIGH
    } state_t;

    // Counter holds cycles elapsed since the last clear event (clear loads 1),
    // so the registered pulse lands exactly TIMEOUT_CYCLES after the clear.
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_ONE  = TIMEOUT_WIDTH'(1);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_gap;
    logic                     r_write;
    logic [7:0]               r_addr;
    logic [15:0]              r_data;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;
    logic                     r_rsp_valid;
    logic                     r_rsp_timeout;
    logic [15:0]              r_rsp_data;

    logic                     w_in_rx;
    logic                     w_tx_ok;
    logic                     w_cnt_expired;
    logic                     w_accept;
    logic                     w_tx_strobe;
    logic [7:0]               w_tx_byte;
    logic                     w_wr_done;
    logic                     w_lo_latch;
    logic                     w_rx_done;
    logic                     w_timeout;
    logic                     w_clr_cnt;
`ifdef RAM_LINK_MASTER_WRITE_VERIFY_EN
    logic                     r_verify;
    logic                     r_rsp_mismatch;
    logic                     w_start_verify;
`endif

    assign w_in_rx       = (r_state == ST_RX_HEADER) || (r_state == ST_RX_LOW) ||
                           (r_state == ST_RX_HIGH);
    // r_gap blocks the cycle right after a strobe, covering a late busy rise.
    assign w_tx_ok       = !bus.tx_busy_i && !r_gap;
    assign w_cnt_expired = (r_cnt >= CNT_LAST);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, Mealy tx strobe and datapath controls
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_tx_strobe  = 1'b0;
        w_tx_byte    = 8'h00;
        w_wr_done    = 1'b0;
        w_lo_latch   = 1'b0;
        w_rx_done    = 1'b0;
        w_timeout    = 1'b0;
        w_clr_cnt    = 1'b0;
`ifdef RAM_LINK_MASTER_WRITE_VERIFY_EN
        w_start_verify = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_TX_HEADER;
                end
            end
            ST_TX_HEADER: begin
                w_tx_byte = HEADER_BYTE;
                if (w_tx_ok) begin
                    w_tx_strobe  = 1'b1;
                    w_state_next = ST_TX_ADDR;
                end
            end
            ST_TX_ADDR: begin
                w_tx_byte = r_addr;
                if (w_tx_ok) begin
                    w_tx_strobe  = 1'b1;
                    w_state_next = ST_TX_RW;
                end
            end
            ST_TX_RW: begin
                w_tx_byte = {7'b0, r_write};
                if (w_tx_ok) begin
                    w_tx_strobe = 1'b1;
                    if (r_write) begin
                        w_state_next = ST_TX_LOW;
                    end else begin
                        w_clr_cnt    = 1'b1;
                        w_state_next = ST_RX_HEADER;
                    end
                end
            end
            ST_TX_LOW: begin
                w_tx_byte = r_data[7:0];
                if (w_tx_ok) begin
                    w_tx_strobe  = 1'b1;
                    w_state_next = ST_TX_HIGH;
                end
            end
            ST_TX_HIGH: begin
                w_tx_byte = r_data[15:8];
                if (w_tx_ok) begin
                    w_tx_strobe = 1'b1;
`ifdef RAM_LINK_MASTER_WRITE_VERIFY_EN
                    // Turn the frame into a read of the same address.
                    w_start_verify = 1'b1;
                    w_state_next   = ST_TX_HEADER;
`else
                    w_wr_done    = 1'b1;
                    w_state_next = ST_IDLE;
`endif
                end
            end
            ST_RX_HEADER: begin
                // Non-header bytes are dropped without restarting the timeout.
                if (bus.new_rx_data_i && (bus.rx_data_i == HEADER_BYTE)) begin
                    w_clr_cnt    = 1'b1;
                    w_state_next = ST_RX_LOW;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_RX_LOW: begin
                if (bus.new_rx_data_i) begin
                    w_lo_latch   = 1'b1;
                    w_clr_cnt    = 1'b1;
                    w_state_next = ST_RX_HIGH;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_RX_HIGH: begin
                if (bus.new_rx_data_i) begin
                    w_rx_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_cnt_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Request latch, gap flag, timeout counter and response registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_gap         <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= 8'h00;
            r_data        <= 16'h0000;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= 16'h0000;
`ifdef RAM_LINK_MASTER_WRITE_VERIFY_EN
            r_verify       <= 1'b0;
            r_rsp_mismatch <= 1'b0;
`endif
        end else begin
            r_gap <= w_tx_strobe;

            if (w_accept) begin
                r_write <= bus.req_write_i;
                r_addr  <= bus.req_addr_i;
                r_data  <= bus.req_data_i;
`ifdef RAM_LINK_MASTER_WRITE_VERIFY_EN
                r_verify <= 1'b0;
`endif
            end
`ifdef RAM_LINK_MASTER_WRITE_VERIFY_EN
            if (w_start_verify) begin
                r_write  <= 1'b0;
                r_verify <= 1'b1;
            end
`endif

            if (w_clr_cnt) begin
                r_cnt <= CNT_ONE;
            end else if (w_in_rx) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= '0;
            end

            r_rsp_valid   <= w_rx_done | w_timeout;
            r_rsp_timeout <= w_timeout;
`ifdef RAM_LINK_MASTER_WRITE_VERIFY_EN
            r_rsp_mismatch <= w_rx_done && r_verify &&
                              ({bus.rx_data_i, r_rsp_data[7:0]} != r_data);
`endif

            if (w_timeout) begin
                r_rsp_data <= 16'h0000;
            end else if (w_wr_done) begin
                r_rsp_data <= r_data;
            end else if (w_lo_latch) begin
                r_rsp_data[7:0] <= bus.rx_data_i;
            end else if (w_rx_done) begin
                r_rsp_data[15:8] <= bus.rx_data_i;
            end
        end
    end

    // Write completion coincides with the final strobe, so it bypasses the registers.
    assign bus.req_ready_o   = (r_state == ST_IDLE);
    assign bus.tx_data_o     = w_tx_byte;
    assign bus.new_tx_data_o = w_tx_strobe;
    assign bus.rsp_valid_o   = r_rsp_valid | w_wr_done;
    assign bus.rsp_data_o    = w_wr_done ? r_data : r_rsp_data;
    assign bus.rsp_timeout_o = r_rsp_timeout;
`ifdef RAM_LINK_MASTER_WRITE_VERIFY_EN
    assign bus.rsp_mismatch_o = r_rsp_mismatch;
`else
    assign bus.rsp_mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_link_master.sv
// Self-checking bench for ram_link_master: a vector table of requests with
// their remote responses, a tx-byte / response scoreboard fed at request time
// and drained by a monitor, plus a hand-written mid-frame reset sequence.
`timescale 1ns/1ps
module tb_ram_link_master;

    localparam int unsigned TO_CYC = 100;
    localparam logic [7:0]  HDR    = 8'h55;
`ifdef RAM_LINK_MASTER_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;
        int          junk;
        logic [15:0] rd;
        bit          silent;
        int          busy;
    } vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic        to;
        logic        mm;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    ram_link_master_if bus ();

    ram_link_master #(
        .HEADER_BYTE   (HDR),
        .TIMEOUT_CYCLES(TO_CYC),
        .TIMEOUT_WIDTH (20)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [7:0]  exp_tx_q[$];
    rsp_t        exp_rsp_q[$];
    int          strobe_q[$];
    int          rsp_cyc = 0;
    int          rsp_count = 0;
    int          busy_len = 0;
    int          busy_left = 0;
    bit          strobe_seen = 1'b0;
    logic [15:0] prev_data = 16'h0000;
    logic [7:0]  mon_b;
    rsp_t        mon_r;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Transmitter model: busy for busy_len cycles after each strobe.
    always @(posedge clk) begin
        #1;
        if (strobe_seen) begin
            busy_left   = busy_len;
            strobe_seen = 1'b0;
        end
        if (busy_left > 0) begin
            bus.tx_busy_i = 1'b1;
            busy_left--;
        end else begin
            bus.tx_busy_i = 1'b0;
        end
    end

    // Monitor: drains the scoreboard queues on tx strobes and responses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.new_tx_data_o) begin
                strobe_q.push_back(cyc);
                strobe_seen = 1'b1;
                if (exp_tx_q.size() == 0) begin
                    check("unexpected_tx_strobe", 1, 0);
                end else begin
                    mon_b = exp_tx_q.pop_front();
                    check("tx_byte", bus.tx_data_o, mon_b);
                end
            end
            if (bus.rsp_valid_o) begin
                rsp_cyc = cyc;
                rsp_count++;
                if (exp_rsp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    mon_r = exp_rsp_q.pop_front();
                    check("rsp_data", bus.rsp_data_o, mon_r.data);
                    check("rsp_timeout", bus.rsp_timeout_o, mon_r.to);
                    check("rsp_mismatch", bus.rsp_mismatch_o, mon_r.mm);
                end
            end else begin
                check("flags_without_valid", {bus.rsp_timeout_o, bus.rsp_mismatch_o}, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, output int c);
        bus.rx_data_i     = b;
        bus.new_rx_data_i = 1'b1;
        c = cyc;
        tick();
        bus.new_rx_data_i = 1'b0;
        tick();
    endtask

    task automatic wait_tx_drain();
        int b = 0;
        while (exp_tx_q.size() != 0 && b < 2000) begin
            tick();
            b++;
        end
        check("tx_drain", exp_tx_q.size(), 0);
        exp_tx_q.delete();
    endtask

    task automatic wait_rsp_drain();
        int b = 0;
        while (exp_rsp_q.size() != 0 && b < 1000) begin
            tick();
            b++;
        end
        check("rsp_drain", exp_rsp_q.size(), 0);
        exp_rsp_q.delete();
    endtask

    function automatic vec_t mk(bit wr, logic [7:0] a, logic [15:0] d, int junk,
                                logic [15:0] rd, bit silent, int busy);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.junk = junk;
        v.rd = rd; v.silent = silent; v.busy = busy;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int   n, nexp, gap, exp_c, exp_last, exp_rsp_c, c, hdr_c, last_c, rc0;
        bit   need_rx;
        rsp_t er;

        check("rsp_valid_idle", bus.rsp_valid_o, 0);
        check("rsp_data_held", bus.rsp_data_o, prev_data);
        check("req_ready_idle", bus.req_ready_o, 1);

        busy_len = v.busy;
        strobe_q.delete();
        rc0     = rsp_count;
        need_rx = !v.wr || VERIFY;
        hdr_c   = 0;
        last_c  = 0;

        exp_tx_q.push_back(HDR);
        exp_tx_q.push_back(v.addr);
        exp_tx_q.push_back({7'b0, v.wr});
        nexp = 3;
        if (v.wr) begin
            exp_tx_q.push_back(v.data[7:0]);
            exp_tx_q.push_back(v.data[15:8]);
            nexp = 5;
            if (VERIFY) begin
                exp_tx_q.push_back(HDR);
                exp_tx_q.push_back(v.addr);
                exp_tx_q.push_back(8'h00);
                nexp = 8;
            end
        end

        if (v.wr && !VERIFY) begin
            er.data = v.data; er.to = 1'b0; er.mm = 1'b0;
        end else if (v.silent) begin
            er.data = 16'h0000; er.to = 1'b1; er.mm = 1'b0;
        end else begin
            er.data = v.rd; er.to = 1'b0; er.mm = v.wr && (v.rd != v.data);
        end
        exp_rsp_q.push_back(er);

        bus.req_valid_i = 1'b1;
        bus.req_write_i = v.wr;
        bus.req_addr_i  = v.addr;
        bus.req_data_i  = v.data;
        n = cyc;
        tick();
        // Requests and rx bytes during the frame must be ignored.
        bus.req_write_i = ~v.wr;
        bus.req_addr_i  = ~v.addr;
        bus.req_data_i  = ~v.data;
        check("req_ready_busy", bus.req_ready_o, 0);
        tick();
        bus.rx_data_i     = HDR;
        bus.new_rx_data_i = 1'b1;
        check("req_ready_busy", bus.req_ready_o, 0);
        tick();
        bus.new_rx_data_i = 1'b0;
        check("req_ready_busy", bus.req_ready_o, 0);
        tick();
        bus.req_valid_i = 1'b0;

        wait_tx_drain();

        if (need_rx) begin
            tick();
            for (int j = 0; j < v.junk; j++) begin
                send_rx((j == 0) ? 8'h00 : 8'hFF, c);
            end
            send_rx(HDR, hdr_c);
            if (!v.silent) begin
                send_rx(v.rd[7:0], c);
                send_rx(v.rd[15:8], last_c);
            end
        end

        wait_rsp_drain();

        gap = (v.busy == 0) ? 2 : v.busy + 1;
        check("strobe_count", strobe_q.size(), nexp);
        exp_c = n + 1;
        exp_last = exp_c;
        for (int k = 0; k < nexp && k < strobe_q.size(); k++) begin
            check("strobe_cycle", strobe_q[k], exp_c);
            exp_last = exp_c;
            exp_c = exp_c + gap;
        end

        if (!need_rx)      exp_rsp_c = exp_last;
        else if (v.silent) exp_rsp_c = hdr_c + TO_CYC;
        else               exp_rsp_c = last_c + 1;
        check("rsp_cycle", rsp_cyc, exp_rsp_c);
        check("rsp_count", rsp_count - rc0, 1);

        prev_data = er.data;
        repeat (v.busy + 3) tick();
    endtask

    vec_t vecs[9];

    initial begin
        int n, rc0;

        rst_n             = 1'b0;
        bus.req_valid_i   = 1'b0;
        bus.req_write_i   = 1'b0;
        bus.req_addr_i    = 8'h00;
        bus.req_data_i    = 16'h0000;
        bus.tx_busy_i     = 1'b0;
        bus.rx_data_i     = 8'h00;
        bus.new_rx_data_i = 1'b0;

        vecs[0] = mk(1'b1, 8'h12, 16'hBEEF, 0, 16'hBEEF, 1'b0, 0);
        vecs[1] = mk(1'b0, 8'h34, 16'h0000, 0, 16'hABCD, 1'b0, 0);
        vecs[2] = mk(1'b0, 8'h56, 16'h0000, 2, 16'h2211, 1'b0, 0);
        vecs[3] = mk(1'b0, 8'h78, 16'h0000, 0, 16'h0000, 1'b1, 0);
        vecs[4] = mk(1'b1, 8'h9A, 16'h5AA5, 0, 16'h5AA5, 1'b0, 20);
        vecs[5] = mk(1'b0, 8'h3C, 16'h0000, 1, 16'h0F0F, 1'b0, 20);
        vecs[6] = mk(1'b1, 8'h40, 16'h1234, 0, 16'h1235, 1'b0, 0);
        vecs[7] = mk(1'b0, 8'hFF, 16'h0000, 0, 16'hFFFF, 1'b0, 0);
        vecs[8] = mk(1'b1, 8'h00, 16'h0000, 0, 16'h0000, 1'b0, 0);

        repeat (3) tick();
        check("reset_req_ready", bus.req_ready_o, 1);
        check("reset_new_tx", bus.new_tx_data_o, 0);
        check("reset_tx_data", bus.tx_data_o, 0);
        check("reset_rsp_valid", bus.rsp_valid_o, 0);
        check("reset_rsp_data", bus.rsp_data_o, 0);
        check("reset_rsp_timeout", bus.rsp_timeout_o, 0);
        check("reset_rsp_mismatch", bus.rsp_mismatch_o, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Reset while the address byte is being strobed abandons the frame.
        busy_len = 0;
        strobe_q.delete();
        rc0 = rsp_count;
        exp_tx_q.push_back(HDR);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b1;
        bus.req_addr_i  = 8'h77;
        bus.req_data_i  = 16'hC3C3;
        n = cyc;
        tick();
        bus.req_valid_i = 1'b0;
        tick();
        tick();
        #1;
        check("mid_addr_strobe", bus.new_tx_data_o, 1);
        check("mid_addr_byte", bus.tx_data_o, 8'h77);
        check("mid_addr_cycle", cyc, n + 3);
        rst_n = 1'b0;
        #1;
        check("async_rst_new_tx", bus.new_tx_data_o, 0);
        check("async_rst_ready", bus.req_ready_o, 1);
        check("async_rst_tx_data", bus.tx_data_o, 0);
        check("async_rst_rsp_data", bus.rsp_data_o, 0);
        tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("rst_no_rsp", rsp_count - rc0, 0);
        check("rst_strobes", strobe_q.size(), 1);
        check("rst_tx_left", exp_tx_q.size(), 0);
        exp_tx_q.delete();
        prev_data = 16'h0000;

        // Link recovers after reset.
        run_vec(mk(1'b0, 8'h21, 16'h0000, 0, 16'h8001, 1'b0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
